// File: rtl/vend_pkg.sv
// Shared vending-machine display definitions: segment encodings,
// credit limit and the conversion FSM state type.
package vend_pkg;

   localparam int MAX_CREDIT = 9999;

   // Segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_COMMIT
   } conv_state_t;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_DIGIT[0];
         4'd1:    s = SEG_DIGIT[1];
         4'd2:    s = SEG_DIGIT[2];
         4'd3:    s = SEG_DIGIT[3];
         4'd4:    s = SEG_DIGIT[4];
         4'd5:    s = SEG_DIGIT[5];
         4'd6:    s = SEG_DIGIT[6];
         4'd7:    s = SEG_DIGIT[7];
         4'd8:    s = SEG_DIGIT[8];
         4'd9:    s = SEG_DIGIT[9];
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   function automatic logic over_max(input logic [31:0] v);
      return v > 32'(MAX_CREDIT);
   endfunction

endpackage

// File: rtl/credit_display_driver_bin2bcd.sv
// Sequential double-dabble converter, one bit per cycle.
// Ports: clk, reset, start, value in; busy, done (last shift), bcd out.
module bin2bcd_seq
   import vend_pkg::*;
#(
   parameter int VAL_W = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [VAL_W-1:0] value,
   output logic             busy,
   output logic             done,
   output logic [15:0]      bcd
);

   localparam int CNT_W = $clog2(VAL_W + 1);

   logic [VAL_W-1:0] bin_q;
   logic [15:0]      bcd_q;
   logic [15:0]      adj;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // High during the final shift; result is valid after this edge
   assign done = busy_q && (cnt_q == CNT_W'(VAL_W - 1));
   assign busy = busy_q;
   assign bcd  = bcd_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (!busy_q && start) begin
         bin_q  <= value;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         bcd_q <= {adj[14:0], bin_q[VAL_W-1]};
         bin_q <= {bin_q[VAL_W-2:0], 1'b0};
         cnt_q <= cnt_q + 1'b1;
         if (done)
            busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/credit_display_driver.sv
// Credit display: converts cents to BCD and scans a 4-digit 7-seg.
// Ports: clk, reset, value, load, blank in; busy, an, seg, dp out.
module credit_display_driver
   import vend_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int DP_POS   = 2,
   parameter int VAL_W    = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [VAL_W-1:0] value,
   input  logic             load,
   input  logic             blank,
   output logic             busy,
   output logic [3:0]       an,
   output logic [6:0]       seg,
   output logic             dp
);

   localparam int TICK_W = $clog2(SCAN_DIV + 1);

   conv_state_t      state;
   logic             pend_v;
   logic [VAL_W-1:0] pend_val;
   logic             ovf_cur;
   logic [3:0]       dig_q [4];
   logic             ovf_q;

   logic             conv_start;
   logic [VAL_W-1:0] conv_val;
   logic             conv_busy;
   logic             conv_done;
   logic [15:0]      conv_bcd;

   logic [TICK_W-1:0] tick;
   logic [1:0]        idx;
   logic              wrap;
   logic [3:0]        lz;
   logic [6:0]        cur_seg;

   // A load arriving in COMMIT overrides any pending value
   assign conv_start = !conv_busy &&
      (((state == S_IDLE) && load) ||
       ((state == S_COMMIT) && (load || pend_v)));
   assign conv_val =
      ((state == S_COMMIT) && !load) ? pend_val : value;

   bin2bcd_seq #(.VAL_W(VAL_W)) u_conv (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .value (conv_val),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         pend_v   <= 1'b0;
         pend_val <= '0;
         ovf_cur  <= 1'b0;
         ovf_q    <= 1'b0;
         for (int k = 0; k < 4; k++)
            dig_q[k] <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (conv_start) begin
                  state   <= S_CONV;
                  busy    <= 1'b1;
                  ovf_cur <= over_max(32'(conv_val));
               end
            end
            S_CONV: begin
               if (load) begin
                  pend_v   <= 1'b1;
                  pend_val <= value;
               end
               if (conv_done)
                  state <= S_COMMIT;
            end
            S_COMMIT: begin
               for (int k = 0; k < 4; k++)
                  dig_q[k] <= conv_bcd[4*k +: 4];
               ovf_q <= ovf_cur;
               if (conv_start) begin
                  state   <= S_CONV;
                  pend_v  <= 1'b0;
                  ovf_cur <= over_max(32'(conv_val));
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign wrap = (tick == TICK_W'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         tick <= '0;
         idx  <= '0;
      end else if (wrap) begin
         tick <= '0;
         idx  <= idx + 2'd1;
      end else begin
         tick <= tick + 1'b1;
      end
   end

   // Leading zeros above the decimal point are blanked
   always_comb begin
      logic z;
      lz = '0;
      z  = 1'b1;
      for (int k = 3; k >= 0; k--) begin
         z     = z && (dig_q[k] == 4'd0);
         lz[k] = z && (k > DP_POS);
      end
   end

   always_comb begin
      if (ovf_q)
         cur_seg = SEG_DASH;
      else if (lz[idx])
         cur_seg = SEG_BLANK;
      else
         cur_seg = seg_of(dig_q[idx]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         an  <= 4'b1111;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
         seg <= cur_seg;
         dp  <= !((idx == 2'(DP_POS)) && !ovf_q);
      end
   end

endmodule

// File: tb/tb_credit_display_driver.sv
// Self-checking bench for credit_display_driver (SCAN_DIV=4).
// Table vectors, hand sequences and random loads vs a decimal model.
`timescale 1ns/1ps
module tb_credit_display_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] value;
   logic        load;
   logic        blank;
   logic        busy;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int              value;
      logic [3:0][6:0] segs;
      logic            ovf;
   } vec_t;

   localparam logic [6:0] TB_SEG [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   vec_t tbl [10];

   always #5 clk = ~clk;

   credit_display_driver #(
      .SCAN_DIV (4),
      .DP_POS   (2),
      .VAL_W    (14)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .value (value),
      .load  (load),
      .blank (blank),
      .busy  (busy),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Decimal model: what each digit position should display
   function automatic logic [3:0][6:0] model_segs(input int v);
      logic [3:0][6:0] r;
      int p;
      p = 1;
      for (int k = 0; k < 4; k++) begin
         if (v > 9999)
            r[k] = 7'h3F;
         else if (k > 2 && v < p)
            r[k] = 7'h7F;
         else
            r[k] = TB_SEG[(v / p) % 10];
         p = p * 10;
      end
      return r;
   endfunction

   task automatic do_load(input int v);
      @(negedge clk);
      value = 14'(v);
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy && cycles < 200) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic scan_check(input logic [3:0][6:0] es,
                             input logic ovf,
                             input string name);
      int cnt [4];
      int k;
      logic exp_dp;
      for (int j = 0; j < 4; j++) cnt[j] = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         k = -1;
         for (int j = 0; j < 4; j++)
            if (an == ~(4'b0001 << j)) k = j;
         if (k < 0) begin
            check({name, " an"}, 32'(an), 32'hE);
         end else begin
            exp_dp = !(k == 2 && !ovf);
            check($sformatf("%s d%0d", name, k),
                  {24'd0, seg, dp}, {24'd0, es[k], exp_dp});
            cnt[k]++;
         end
      end
      for (int j = 0; j < 4; j++)
         check($sformatf("%s slots%0d", name, j), cnt[j], 4);
   endtask

   initial begin
      int cyc;
      int v;
      int drop_at;
      logic [3:0][6:0] es;

      tbl[0] = '{value: 0,     segs: {7'h7F, 7'h40, 7'h40, 7'h40}, ovf: 1'b0};
      tbl[1] = '{value: 5,     segs: {7'h7F, 7'h40, 7'h40, 7'h12}, ovf: 1'b0};
      tbl[2] = '{value: 1250,  segs: {7'h79, 7'h24, 7'h12, 7'h40}, ovf: 1'b0};
      tbl[3] = '{value: 12000, segs: {7'h3F, 7'h3F, 7'h3F, 7'h3F}, ovf: 1'b1};
      tbl[4] = '{value: 9999,  segs: {7'h10, 7'h10, 7'h10, 7'h10}, ovf: 1'b0};
      tbl[5] = '{value: 10000, segs: {7'h3F, 7'h3F, 7'h3F, 7'h3F}, ovf: 1'b1};
      tbl[6] = '{value: 100,   segs: {7'h7F, 7'h79, 7'h40, 7'h40}, ovf: 1'b0};
      tbl[7] = '{value: 1000,  segs: {7'h79, 7'h40, 7'h40, 7'h40}, ovf: 1'b0};
      tbl[8] = '{value: 1005,  segs: {7'h79, 7'h40, 7'h40, 7'h12}, ovf: 1'b0};
      tbl[9] = '{value: 3040,  segs: {7'h30, 7'h40, 7'h19, 7'h40}, ovf: 1'b0};

      reset = 1'b1;
      value = '0;
      load  = 1'b0;
      blank = 1'b0;
      repeat (3) @(negedge clk);
      check("rst an", 32'(an), 32'hF);
      check("rst seg", 32'(seg), 32'h7F);
      reset = 1'b0;

      // Reset asserted in the middle of a scan
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid rst an", 32'(an), 32'hF);
      check("mid rst seg", 32'(seg), 32'h7F);
      check("mid rst dp", 32'(dp), 32'h1);
      check("mid rst busy", 32'(busy), 32'h0);
      reset = 1'b0;
      scan_check(model_segs(0), 1'b0, "post rst");

      // Table-driven vectors
      for (int t = 0; t < 10; t++) begin
         do_load(tbl[t].value);
         wait_idle(cyc);
         check($sformatf("busy len %0d", tbl[t].value), cyc, 15);
         scan_check(tbl[t].segs, tbl[t].ovf,
                    $sformatf("vec %0d", tbl[t].value));
      end

      // Reset mid-conversion with a pending load: both dropped
      do_load(1250);
      do_load(777);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", 32'(busy), 32'h0);
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) cyc++;
      end
      check("abort no restart", cyc, 0);
      scan_check(model_segs(0), 1'b0, "abort");

      // Load 300, then 4321 three cycles later
      do_load(300);
      @(negedge clk);
      do_load(4321);
      es = model_segs(300);
      drop_at = -1;
      for (int i = 4; i <= 30; i++) begin
         @(negedge clk);
         if (!busy && drop_at < 0) drop_at = i;
         if (i >= 16) begin
            for (int j = 0; j < 4; j++)
               if (an == ~(4'b0001 << j))
                  check($sformatf("pend 300 c%0d", i),
                        32'(seg), 32'(es[j]));
         end
      end
      check("pend busy drop", drop_at, 30);
      scan_check(model_segs(4321), 1'b0, "pend 4321");

      // Blank held during a conversion
      @(negedge clk);
      blank = 1'b1;
      do_load(8642);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("blank an c%0d", i), 32'(an), 32'hF);
      end
      blank = 1'b0;
      scan_check(model_segs(8642), 1'b0, "unblank");

      // Random loads against the decimal model
      for (int r = 0; r < 20; r++) begin
         v = int'($urandom_range(0, 16383));
         do_load(v);
         wait_idle(cyc);
         check($sformatf("rnd busy %0d", v), cyc, 15);
         scan_check(model_segs(v), v > 9999,
                    $sformatf("rnd %0d", v));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
